mips_single_cycle: RTL and testbench

Single-cycle 32-bit MIPS processor core, the top of the CPU design. Each clock it fetches one instruction from internal instruction ROM, decodes it, executes it in the ALU, optionally accesses internal data RAM, writes back to the register file and advances the PC. The decoded control signals are exported as ports for observation by benches and debug logic.

---
 rtl/mips_pkg.sv | 61 ++++++
 rtl/mips_control.sv | 82 ++++++++
 rtl/mips_single_cycle.sv | 150 +++++++++++++++
 tb/tb_mips_single_cycle.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the single-cycle MIPS core.
//   - opcode constants for the supported instructions
//   - R-type funct constants
//   - ALUOp encodings produced by the control decoder
//   - ALU operation enum and the ALUOp/funct -> operation decode helper
// ---------------------------------------------------------------------------
package mips_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct field (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  // Unknown funct codes and the unused ALUOp value fall back to add.
  function automatic alu_op_e alu_decode(input logic [1:0] alu_op,
                                         input logic [5:0] funct);
    alu_op_e op;
    op = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  op = ALU_SUB;
          FN_AND:  op = ALU_AND;
          FN_OR:   op = ALU_OR;
          FN_SLT:  op = ALU_SLT;
          default: op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mips_control.sv
// ---------------------------------------------------------------------------
// mips_control
// Main control decoder: maps the 6-bit opcode to the datapath controls.
// Optional feature macro: MIPS_BNE_EN (when undefined, bne decodes as NOP
// and o_bne is tied low).
//   i_opcode      instr[31:26]
//   o_alu_op      ALUOp (00 add, 01 sub, 10 decode by funct)
//   o_reg_dst     1: write rd, 0: write rt
//   o_alu_src     1: ALU B = sign-extended imm16
//   o_mem_to_reg  1: write-back from data RAM
//   o_reg_write   register file write enable
//   o_mem_read    data RAM read
//   o_mem_write   data RAM write enable
//   o_branch      beq
//   o_jump        j
//   o_bne         bne
// ---------------------------------------------------------------------------
module mips_control
  import mips_pkg::*;
(
  input  logic [5:0] i_opcode,
  output logic [1:0] o_alu_op,
  output logic       o_reg_dst,
  output logic       o_alu_src,
  output logic       o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_branch,
  output logic       o_jump,
  output logic       o_bne
);

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    o_alu_op     = ALUOP_ADD;
    o_reg_dst    = 1'b0;
    o_alu_src    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_branch     = 1'b0;
    o_jump       = 1'b0;
    o_bne        = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_reg_dst   = 1'b1;
        o_reg_write = 1'b1;
        o_alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        o_alu_src    = 1'b1;
        o_mem_to_reg = 1'b1;
        o_reg_write  = 1'b1;
        o_mem_read   = 1'b1;
      end
      OP_SW: begin
        o_alu_src   = 1'b1;
        o_mem_write = 1'b1;
      end
      OP_BEQ: begin
        o_branch = 1'b1;
        o_alu_op = ALUOP_SUB;
      end
`ifdef MIPS_BNE_EN
      OP_BNE: begin
        o_bne    = 1'b1;
        o_alu_op = ALUOP_SUB;
      end
`endif
      OP_ADDI: begin
        o_alu_src   = 1'b1;
        o_reg_write = 1'b1;
      end
      OP_J: o_jump = 1'b1;
      default: ;  // unknown opcode: NOP
    endcase
  end

endmodule

// File: rtl/mips_single_cycle.sv
// ---------------------------------------------------------------------------
// mips_single_cycle
// Single-cycle 32-bit MIPS core: instruction ROM, register file, ALU, data
// RAM and PC logic. One instruction completes per rising clock edge.
// Optional feature macro: MIPS_BNE_EN (bne support, decoded in mips_control).
// Parameters:
//   IMEM_FILE   name of the instruction ROM image (the ROM contents are
//               provided by the environment)
//   IMEM_WORDS  instruction ROM depth in words
//   DMEM_WORDS  data RAM depth in words
// Ports:
//   clk       clock, rising edge
//   res       asynchronous active-low reset (PC and registers)
//   OpCode    instr[31:26] of the current instruction
//   ALUOp, RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite,
//   Branch, Jump, Bne   decoded controls of the current instruction
// ---------------------------------------------------------------------------
module mips_single_cycle
  import mips_pkg::*;
#(
  parameter string IMEM_FILE  = "imem.hex",
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_WORDS = 64
) (
  input  logic       clk,
  input  logic       res,
  output logic [5:0] OpCode,
  output logic [1:0] ALUOp,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic       Jump,
  output logic       Bne
);

  localparam int IMEM_AW = $clog2(IMEM_WORDS);
  localparam int DMEM_AW = $clog2(DMEM_WORDS);

  logic [31:0] r_imem [IMEM_WORDS];
  logic [31:0] r_dmem [DMEM_WORDS];
  logic [31:0] r_regs [32];
  logic [31:0] r_pc;

  // The data RAM is set up once at time 0 and is intentionally left alone
  // by reset so stored data survives a restart.
  initial begin
    for (int i = 0; i < DMEM_WORDS; i++) r_dmem[i] = '0;
  end

  // ---------------- fetch / decode ----------------
  logic [31:0] w_instr;
  logic [4:0]  w_rs, w_rt, w_rd, w_waddr;
  logic [5:0]  w_funct;
  logic [31:0] w_imm_sext;
  logic        w_unused;

  assign w_instr    = r_imem[r_pc[IMEM_AW+1:2]];
  assign OpCode     = w_instr[31:26];
  assign w_rs       = w_instr[25:21];
  assign w_rt       = w_instr[20:16];
  assign w_rd       = w_instr[15:11];
  assign w_funct    = w_instr[5:0];
  assign w_imm_sext = {{16{w_instr[15]}}, w_instr[15:0]};
  assign w_unused   = ^w_instr[10:6];  // shamt is not used by any instruction

  mips_control u_control (
    .i_opcode     (OpCode),
    .o_alu_op     (ALUOp),
    .o_reg_dst    (RegDst),
    .o_alu_src    (ALUSrc),
    .o_mem_to_reg (MemToReg),
    .o_reg_write  (RegWrite),
    .o_mem_read   (MemRead),
    .o_mem_write  (MemWrite),
    .o_branch     (Branch),
    .o_jump       (Jump),
    .o_bne        (Bne)
  );

  // ---------------- register read ----------------
  logic [31:0] w_rd1, w_rd2;
  assign w_rd1 = (w_rs == 5'd0) ? '0 : r_regs[w_rs];
  assign w_rd2 = (w_rt == 5'd0) ? '0 : r_regs[w_rt];

  // ---------------- ALU ----------------
  alu_op_e     w_alu_op;
  logic [31:0] w_alu_b, w_alu_res;
  logic        w_zero;

  assign w_alu_op = alu_decode(ALUOp, w_funct);
  assign w_alu_b  = ALUSrc ? w_imm_sext : w_rd2;

  always_comb begin
    w_alu_res = w_rd1 + w_alu_b;
    case (w_alu_op)
      ALU_SUB: w_alu_res = w_rd1 - w_alu_b;
      ALU_AND: w_alu_res = w_rd1 & w_alu_b;
      ALU_OR:  w_alu_res = w_rd1 | w_alu_b;
      ALU_SLT: w_alu_res = {31'd0, $signed(w_rd1) < $signed(w_alu_b)};
      default: w_alu_res = w_rd1 + w_alu_b;
    endcase
  end

  assign w_zero = (w_alu_res == 32'd0);

  // ---------------- memory / write-back ----------------
  logic [31:0] w_dmem_rdata, w_wb_data;
  assign w_dmem_rdata = r_dmem[w_alu_res[DMEM_AW+1:2]];
  assign w_wb_data    = MemToReg ? w_dmem_rdata : w_alu_res;
  assign w_waddr      = RegDst ? w_rd : w_rt;

  // ---------------- next PC ----------------
  logic [31:0] w_pc4, w_br_target, w_pc_next;
  logic        w_take_br;

  assign w_pc4       = r_pc + 32'd4;
  assign w_br_target = w_pc4 + {w_imm_sext[29:0], 2'b00};
  assign w_take_br   = (Branch & w_zero) | (Bne & ~w_zero);

  always_comb begin
    w_pc_next = w_pc4;
    if (Jump)           w_pc_next = {w_pc4[31:28], w_instr[25:0], 2'b00};
    else if (w_take_br) w_pc_next = w_br_target;
  end

  // ---------------- state update ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reads of a register being written this
  // cycle therefore see the old contents.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_pc <= '0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (RegWrite && (w_waddr != 5'd0)) r_regs[w_waddr] <= w_wb_data;
    end
  end

  // NOTE: the data RAM has no reset branch, which keeps it mappable to a
  // RAM macro; writes are simply blocked while res is low.
  always_ff @(posedge clk) begin
    if (res && MemWrite) r_dmem[w_alu_res[DMEM_AW+1:2]] <= w_rd2;
  end

endmodule

// File: tb/tb_mips_single_cycle.sv
// ---------------------------------------------------------------------------
// tb_mips_single_cycle
// Self-checking bench for mips_single_cycle. Programs are written straight
// into the instruction ROM. A directed program is checked against a table of
// expected PC/decode values, then random programs are checked against an
// instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_mips_single_cycle;

  logic       clk, res;
  logic [5:0] OpCode;
  logic [1:0] ALUOp;
  logic       RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite;
  logic       Branch, Jump, Bne;

  mips_single_cycle #(
    .IMEM_FILE  (""),
    .IMEM_WORDS (64),
    .DMEM_WORDS (64)
  ) dut (
    .clk      (clk),
    .res      (res),
    .OpCode   (OpCode),
    .ALUOp    (ALUOp),
    .RegDst   (RegDst),
    .ALUSrc   (ALUSrc),
    .MemToReg (MemToReg),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .Jump     (Jump),
    .Bne      (Bne)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [31:0] m_prog [64];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [64];
  logic [31:0] m_pc;

  task automatic load_rom();
    for (int i = 0; i < 64; i++) dut.r_imem[i] = m_prog[i];
  endtask

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  task automatic model_write(input logic [4:0] idx, input logic [31:0] val);
    if (idx != 5'd0) m_regs[idx] = val;
  endtask

  // Executes one instruction at m_pc using the architectural rules.
  task automatic model_step();
    logic [31:0] ins, a, b, sx, pc4, nxt, addr;
    ins  = m_prog[(m_pc >> 2) % 64];
    a    = m_regs[ins[25:21]];
    b    = m_regs[ins[20:16]];
    sx   = {{16{ins[15]}}, ins[15:0]};
    pc4  = m_pc + 32'd4;
    nxt  = pc4;
    addr = a + sx;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h22:   model_write(ins[15:11], a - b);
          6'h24:   model_write(ins[15:11], a & b);
          6'h25:   model_write(ins[15:11], a | b);
          6'h2A:   model_write(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          default: model_write(ins[15:11], a + b);
        endcase
      end
      6'h23: model_write(ins[20:16], m_dmem[(addr >> 2) % 64]);
      6'h2B: m_dmem[(addr >> 2) % 64] = b;
      6'h04: if (a == b) nxt = pc4 + (sx << 2);
`ifdef MIPS_BNE_EN
      6'h05: if (a != b) nxt = pc4 + (sx << 2);
`endif
      6'h08: model_write(ins[20:16], a + sx);
      6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    m_pc = nxt;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [5:0]  fn, op;
    logic [15:0] imm;
    int          off;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    off = int'($urandom_range(0, 8)) - 4;
    case ($urandom_range(0, 5))
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      4: fn = 6'h2A;
      default: fn = 6'h27;  // unlisted funct behaves as add
    endcase
    case ($urandom_range(0, 2))
      0: op = 6'h3F;
      1: op = 6'h0F;
      default: op = 6'h01;
    endcase
    case ($urandom_range(0, 10))
      0, 1: return {6'h00, rs, rt, rd, 5'd0, fn};
      2:    return {6'h23, rs, rt, 16'($urandom_range(0, 255))};
      3:    return {6'h2B, rs, rt, 16'($urandom_range(0, 255))};
      4:    return {6'h04, rs, rt, 16'(off)};
      5:    return {6'h05, rs, rt, 16'(off)};
      6, 7: return {6'h08, rs, rt, imm};
      8:    return {6'h02, 26'($urandom_range(0, 63))};
      9:    return {op, 26'($urandom)};
      default: return {6'h00, rs, rt, rd, 5'd0, fn};
    endcase
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [1:0]  alu_op;
    logic [8:0]  ctrl;  // {RegDst,ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,Branch,Jump,Bne}
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  function automatic logic [8:0] ctrl_now();
    return {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, Jump, Bne};
  endfunction

  initial begin
    logic [31:0] exp_regs [9];
    logic [1:0]  bne_aluop;
    logic [8:0]  bne_ctrl;

`ifdef MIPS_BNE_EN
    bne_aluop = 2'b01;
    bne_ctrl  = 9'b000000001;
`else
    bne_aluop = 2'b00;
    bne_ctrl  = 9'b000000000;
`endif

    vecs[0]  = '{32'd0,  6'h08, 2'b00, 9'b010100000};  // addi $1,$0,5
    vecs[1]  = '{32'd4,  6'h08, 2'b00, 9'b010100000};  // addi $2,$0,7
    vecs[2]  = '{32'd8,  6'h00, 2'b10, 9'b100100000};  // add $3,$1,$2
    vecs[3]  = '{32'd12, 6'h00, 2'b10, 9'b100100000};  // sub $4,$2,$1
    vecs[4]  = '{32'd16, 6'h00, 2'b10, 9'b100100000};  // slt $5,$1,$2
    vecs[5]  = '{32'd20, 6'h2B, 2'b00, 9'b010001000};  // sw $3,4($0)
    vecs[6]  = '{32'd24, 6'h23, 2'b00, 9'b011110000};  // lw $6,4($0)
    vecs[7]  = '{32'd28, 6'h04, 2'b01, 9'b000000100};  // beq $1,$1,+2
    vecs[8]  = '{32'd40, 6'h05, bne_aluop, bne_ctrl};  // bne $1,$1,+2
    vecs[9]  = '{32'd44, 6'h08, 2'b00, 9'b010100000};  // addi $0,$0,9
    vecs[10] = '{32'd48, 6'h3F, 2'b00, 9'b000000000};  // undefined opcode
    vecs[11] = '{32'd52, 6'h02, 2'b00, 9'b000000010};  // j 0x10
    vecs[12] = '{32'd64, 6'h08, 2'b00, 9'b010100000};  // addi $8,$0,-1
    vecs[13] = '{32'd68, 6'h02, 2'b00, 9'b000000010};  // j 0x11 (self loop)

    for (int i = 0; i < 64; i++) m_prog[i] = 32'd0;
    m_prog[0]  = 32'h20010005;
    m_prog[1]  = 32'h20020007;
    m_prog[2]  = 32'h00221820;
    m_prog[3]  = 32'h00412022;
    m_prog[4]  = 32'h0022282A;
    m_prog[5]  = 32'hAC030004;
    m_prog[6]  = 32'h8C060004;
    m_prog[7]  = 32'h10210002;
    m_prog[8]  = 32'h20070001;  // skipped
    m_prog[9]  = 32'h20070002;  // skipped
    m_prog[10] = 32'h14210002;
    m_prog[11] = 32'h20000009;
    m_prog[12] = 32'hFC000000;
    m_prog[13] = 32'h08000010;
    m_prog[14] = 32'h20070003;  // skipped by the jump
    m_prog[16] = 32'h2008FFFF;
    m_prog[17] = 32'h08000011;

    exp_regs = '{32'd0, 32'd5, 32'd7, 32'd12, 32'd2, 32'd1, 32'd12, 32'd0, 32'hFFFFFFFF};

    // ---- reset ----
    res = 1'b1;
    load_rom();
    #1 res = 1'b0;
    #10;
    check("reset_pc", dut.r_pc, 32'd0);
    for (int i = 0; i < 32; i++)
      check($sformatf("reset_reg%0d", i), dut.r_regs[i], 32'd0);
    check("reset_opcode", 32'(OpCode), 32'h08);

    @(negedge clk) res = 1'b1;

    // ---- directed program ----
    for (int i = 0; i < NVEC; i++) begin
      check($sformatf("dir_pc_%0d", i),     dut.r_pc,       vecs[i].pc);
      check($sformatf("dir_op_%0d", i),     32'(OpCode),    32'(vecs[i].op));
      check($sformatf("dir_aluop_%0d", i),  32'(ALUOp),     32'(vecs[i].alu_op));
      check($sformatf("dir_ctrl_%0d", i),   32'(ctrl_now()), 32'(vecs[i].ctrl));
      @(negedge clk);
    end
    check("dir_pc_loop", dut.r_pc, 32'd68);
    for (int i = 0; i < 9; i++)
      check($sformatf("dir_reg%0d", i), dut.r_regs[i], exp_regs[i]);
    check("dir_dmem1", dut.r_dmem[1], 32'd12);

    // ---- asynchronous reset mid-program; RAM keeps its contents ----
    #2 res = 1'b0;
    #1;
    check("midrst_pc", dut.r_pc, 32'd0);
    check("midrst_reg3", dut.r_regs[3], 32'd0);
    check("midrst_dmem1", dut.r_dmem[1], 32'd12);
    repeat (2) @(posedge clk);
    #1;
    check("inrst_pc_hold", dut.r_pc, 32'd0);
    check("inrst_reg1_hold", dut.r_regs[1], 32'd0);
    @(negedge clk) res = 1'b1;
    @(negedge clk);
    check("restart_pc", dut.r_pc, 32'd4);
    check("restart_reg1", dut.r_regs[1], 32'd5);

    // ---- random programs against the reference model ----
    for (int i = 0; i < 64; i++) m_dmem[i] = 32'd0;
    m_dmem[1] = 32'd12;
    for (int p = 0; p < 6; p++) begin
      @(negedge clk) res = 1'b0;
      for (int i = 0; i < 64; i++) m_prog[i] = rand_instr();
      load_rom();
      model_reset();
      @(negedge clk) res = 1'b1;
      for (int c = 0; c < 150; c++) begin
        check($sformatf("rnd%0d_pc_c%0d", p, c), dut.r_pc, m_pc);
        check($sformatf("rnd%0d_op_c%0d", p, c), 32'(OpCode),
              32'(m_prog[(m_pc >> 2) % 64][31:26]));
        model_step();
        @(negedge clk);
      end
      for (int i = 1; i < 32; i++)
        check($sformatf("rnd%0d_reg%0d", p, i), dut.r_regs[i], m_regs[i]);
      for (int i = 0; i < 64; i++)
        check($sformatf("rnd%0d_dmem%0d", p, i), dut.r_dmem[i], m_dmem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
